register_file_2r1w: RTL and testbench



---
 rtl/register_file_2r1w.sv | 46 ++++
 tb/tb_register_file_2r1w.sv | 111 +++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: MIPS 2-read/1-write register file, r0 reads zero, SP entry loads SP_RESET_VALUE on reset.
// Define REG_FILE_BYPASS_EN to forward a same-cycle write to the read ports.
module register_file_2r1w #(
    parameter int          N              = 32,
    parameter int          DEPTH          = 32,
    parameter int          ADDR_W         = 5,
    parameter int          SP_INDEX       = 29,
    parameter logic [31:0] SP_RESET_VALUE = 32'h7FFF_EFFC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_i,
    input  logic [ADDR_W-1:0] write_register_i,
    input  logic [N-1:0]      write_data_i,
    input  logic [ADDR_W-1:0] read_register_1_i,
    input  logic [ADDR_W-1:0] read_register_2_i,
    output logic [N-1:0]      read_data_1_o,
    output logic [N-1:0]      read_data_2_o
);
    localparam logic [N-1:0] sp_rst = N'(SP_RESET_VALUE);
    logic [N-1:0] regs [1:DEPTH-1];
    logic [N-1:0] stored_1, stored_2;
    // Only indices 1..DEPTH-1 exist, so r0 and out-of-range writes fall through untouched
    always_ff @(posedge clk)
        for (int j = 1; j < DEPTH; j++)
            if (reset) regs[j] <= (j == SP_INDEX) ? sp_rst : '0;
            else if (reg_write_i && write_register_i == ADDR_W'(j)) regs[j] <= write_data_i;
    always_comb begin
        stored_1 = '0;
        stored_2 = '0;
        for (int j = 1; j < DEPTH; j++) begin
            stored_1 = (read_register_1_i == ADDR_W'(j)) ? regs[j] : stored_1;
            stored_2 = (read_register_2_i == ADDR_W'(j)) ? regs[j] : stored_2;
        end
    end
`ifdef REG_FILE_BYPASS_EN
    localparam logic [ADDR_W:0] depth_w = (ADDR_W + 1)'(DEPTH);
    logic wr_hit;
    assign wr_hit = reg_write_i && !reset && |write_register_i && ({1'b0, write_register_i} < depth_w);
    assign read_data_1_o = (wr_hit && write_register_i == read_register_1_i) ? write_data_i : stored_1;
    assign read_data_2_o = (wr_hit && write_register_i == read_register_2_i) ? write_data_i : stored_2;
`else
    assign read_data_1_o = stored_1;
    assign read_data_2_o = stored_2;
`endif
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: table-driven check of a 32-entry and a 16-entry register file sharing one stimulus bus.
module tb_register_file_2r1w;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        bit          rst;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          sel16;
    } vec_t;
    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        bit          sel16;
        int          idx;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1, rd2, sd1, sd2;
    vec_t        vt[$];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    always #5 clk = ~clk;
    register_file_2r1w dut (
        .clk(clk), .reset(reset), .reg_write_i(we), .write_register_i(wa), .write_data_i(wd),
        .read_register_1_i(ra1), .read_register_2_i(ra2), .read_data_1_o(rd1), .read_data_2_o(rd2)
    );
    register_file_2r1w #(.DEPTH(16)) dut16 (
        .clk(clk), .reset(reset), .reg_write_i(we), .write_register_i(wa), .write_data_i(wd),
        .read_register_1_i(ra1), .read_register_2_i(ra2), .read_data_1_o(sd1), .read_data_2_o(sd2)
    );
    function automatic void add(bit rst, bit w, logic [4:0] a, logic [31:0] d, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] x1, logic [31:0] x2, bit s);
        vt.push_back('{rst, w, a, d, r1, r2, x1, x2, s});
    endfunction
    initial begin
        logic [31:0] m16 [16];
        exp_t        e;
        logic [31:0] a1, a2;
        // 32-entry instance: reset, r0 immunity, dual read, hazard, reset-vs-write
        add(1, 0, 0,  0,            0,  0,  0,                                  0,                                  0);
        add(0, 0, 0,  0,            0,  5,  0,                                  0,                                  0);
        add(0, 0, 0,  0,            29, 5,  32'h7FFF_EFFC,                      0,                                  0);
        add(0, 1, 0,  32'hDEAD_BEEF, 0,  0,  0,                                  0,                                  0);
        add(0, 1, 8,  32'h1234_5678, 0,  0,  0,                                  0,                                  0);
        add(0, 1, 31, 32'hCAFE_0001, 8,  0,  32'h1234_5678,                      0,                                  0);
        add(0, 0, 0,  0,            8,  31, 32'h1234_5678,                      32'hCAFE_0001,                      0);
        add(0, 0, 0,  0,            8,  8,  32'h1234_5678,                      32'h1234_5678,                      0);
        add(0, 1, 9,  32'h0000_0011, 1,  2,  0,                                  0,                                  0);
        add(0, 1, 9,  32'h0000_0022, 9,  9,  BYP ? 32'h22 : 32'h11,             BYP ? 32'h22 : 32'h11,             0);
        add(0, 0, 0,  0,            9,  31, 32'h0000_0022,                      32'hCAFE_0001,                      0);
        add(0, 1, 29, 32'h0000_1000, 29, 4,  BYP ? 32'h1000 : 32'h7FFF_EFFC,    0,                                  0);
        add(0, 0, 0,  0,            29, 9,  32'h0000_1000,                      32'h0000_0022,                      0);
        add(1, 1, 4,  32'hFFFF_FFFF, 4,  29, 0,                                  32'h0000_1000,                      0);
        add(0, 0, 0,  0,            4,  29, 0,                                  32'h7FFF_EFFC,                      0);
        add(0, 0, 0,  0,            8,  31, 0,                                  0,                                  0);
        // 16-entry instance: out-of-range writes/reads, SP_INDEX ignored
        add(1, 0, 0,  0,            0,  0,  0,                                  0,                                  1);
        add(0, 1, 15, 32'h5A5A_5A5A, 13, 15, 0,                                  BYP ? 32'h5A5A_5A5A : 32'h0,        1);
        add(0, 1, 20, 32'hAAAA_AAAA, 20, 4,  0,                                  0,                                  1);
        add(0, 1, 29, 32'h1234_5678, 20, 13, 0,                                  0,                                  1);
        add(0, 0, 0,  0,            20, 15, 0,                                  32'h5A5A_5A5A,                      1);
        foreach (m16[k]) m16[k] = '0;
        m16[15] = 32'h5A5A_5A5A;
        for (int a = 0; a < 16; a += 2)
            add(0, 0, 0, 0, 5'(a), 5'(a + 1), m16[a], m16[a + 1], 1);
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            reset = vt[i].rst;
            we    = vt[i].we;
            wa    = vt[i].wa;
            wd    = vt[i].wd;
            ra1   = vt[i].ra1;
            ra2   = vt[i].ra2;
            sb.push_back('{vt[i].e1, vt[i].e2, vt[i].sel16, i});
            #2;
            e  = sb.pop_front();
            a1 = e.sel16 ? sd1 : rd1;
            a2 = e.sel16 ? sd2 : rd2;
            n_vec++;
            if (a1 !== e.e1) begin
                n_miss++;
                $display("FAIL vec%0d port1: got %h, want %h", e.idx, a1, e.e1);
            end
            if (a2 !== e.e2) begin
                n_miss++;
                $display("FAIL vec%0d port2: got %h, want %h", e.idx, a2, e.e2);
            end
        end
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
